// File: rtl/vend_pkg.sv
// Shared coin codes, controller state encoding and coin valuation for the vending controller.
package vend_pkg;

  localparam logic [1:0] COIN_NONE    = 2'b00;
  localparam logic [1:0] COIN_NICKEL  = 2'b01;
  localparam logic [1:0] COIN_DIME    = 2'b10;
  localparam logic [1:0] COIN_INVALID = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } vend_state_t;

  // Value in nickel units; invalid and empty codes are worth nothing.
  function automatic logic [1:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_NICKEL: return 2'd1;
      COIN_DIME:   return 2'd2;
      default:     return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_timeout_ctr.sv
// Inactivity counter for the COLLECT state; expired flags the last idle cycle before refund.
module vend_timeout_ctr #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/vend_controller.sv
// Coin-credit vending controller: collects credit, requests a vend at price, then pays change
// one nickel at a time. Handles cancel/refund and inactivity timeout.
module vend_controller
  import vend_pkg::*;
#(
  parameter int PRICE_UNITS = 3,
  parameter int CREDIT_W    = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          coin,
  input  logic                cancel,
  output logic                vend_req,
  input  logic                vend_ack,
  output logic                change_req,
  input  logic                change_ack,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output vend_state_t         dbg_state
);

  localparam logic [CREDIT_W-1:0] PRICE = CREDIT_W'(PRICE_UNITS);

  vend_state_t         state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                reject_q, reject_d;

  logic [CREDIT_W:0]   credit_sum;
  logic [CREDIT_W-1:0] credit_col;
  logic [CREDIT_W-1:0] remainder;
  logic                coin_offered;
  logic                coin_accept;
  logic                tmo_clear;
  logic                tmo_enable;
  logic                tmo_expired;

  // One extra bit on the sum catches a coin that would wrap the credit register.
  assign credit_sum   = {1'b0, credit_q} + (CREDIT_W + 1)'(coin_value(coin));
  assign coin_offered = (coin == COIN_NICKEL) || (coin == COIN_DIME);
  assign coin_accept  = ((state_q == IDLE) || (state_q == COLLECT)) && coin_offered
                        && !credit_sum[CREDIT_W];
  assign credit_col   = coin_accept ? credit_sum[CREDIT_W-1:0] : credit_q;
  assign remainder    = credit_q - PRICE;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      credit_q <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      reject_q <= reject_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    reject_d = (coin != COIN_NONE) && !coin_accept;
    case (state_q)
      IDLE: begin
        if (coin_accept) begin
          credit_d = credit_col;
          state_d  = COLLECT;
        end
      end
      COLLECT: begin
        credit_d = credit_col;
        if (cancel) begin
          state_d = CHANGE;
        end else if (credit_col >= PRICE) begin
          state_d = VEND;
        end else if (tmo_expired && !coin_accept) begin
          state_d = CHANGE;
        end
      end
      VEND: begin
        if (vend_ack) begin
          credit_d = remainder;
          state_d  = (remainder != '0) ? CHANGE : IDLE;
        end
      end
      CHANGE: begin
        if (change_ack) begin
          credit_d = credit_q - CREDIT_W'(1);
          if (credit_q == CREDIT_W'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        credit_d = '0;
      end
    endcase
  end

  // Outputs are decoded from registered state only.
  always_comb begin
    vend_req    = (state_q == VEND);
    change_req  = (state_q == CHANGE);
    busy        = (state_q == VEND) || (state_q == CHANGE);
    coin_reject = reject_q;
    credit      = credit_q;
    dbg_state   = state_q;
  end

  // Counter restarts on every accepted coin and sits at zero whenever COLLECT is left.
  assign tmo_clear  = (state_d != COLLECT) || coin_accept;
  assign tmo_enable = (state_q == COLLECT);

  vend_timeout_ctr #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmo_clear),
    .enable (tmo_enable),
    .expired(tmo_expired)
  );

endmodule

// File: tb/tb_vend_controller.sv
// Directed table-driven bench for vend_controller, plus a narrow-credit instance for saturation.
module tb_vend_controller;
  import vend_pkg::*;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [1:0] coin = COIN_NONE;
  logic       cancel = 1'b0, vend_ack = 1'b0, change_ack = 1'b0;
  logic       vend_req, change_req, coin_reject, busy;
  logic [3:0] credit;
  vend_state_t dbg_state;

  logic       rst2 = 1'b1;
  logic [1:0] coin2 = COIN_NONE;
  logic       vend_ack2 = 1'b0;
  logic       vend_req2, change_req2, coin_reject2, busy2;
  logic [1:0] credit2;
  vend_state_t dbg_state2;

  vend_controller #(.PRICE_UNITS(3), .CREDIT_W(4), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst), .coin(coin), .cancel(cancel),
    .vend_req(vend_req), .vend_ack(vend_ack),
    .change_req(change_req), .change_ack(change_ack),
    .coin_reject(coin_reject), .credit(credit), .busy(busy), .dbg_state(dbg_state)
  );

  vend_controller #(.PRICE_UNITS(3), .CREDIT_W(2), .TIMEOUT_CYC(1000)) dut2 (
    .clk(clk), .rst(rst2), .coin(coin2), .cancel(1'b0),
    .vend_req(vend_req2), .vend_ack(vend_ack2),
    .change_req(change_req2), .change_ack(1'b0),
    .coin_reject(coin_reject2), .credit(credit2), .busy(busy2), .dbg_state(dbg_state2)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  coin;
    logic        cancel;
    logic        vack;
    logic        cack;
    vend_state_t st;
    logic [3:0]  credit;
    logic        vreq;
    logic        creq;
    logic        rej;
    logic        busy;
  } vec_t;

  vec_t vecs[$];
  int   total  = 0;
  int   passed = 0;

  task automatic add(input logic r, input logic [1:0] c, input logic can, input logic va,
                     input logic ca, input vend_state_t st, input int cr,
                     input logic vr, input logic chr, input logic rj, input logic bz);
    vec_t v;
    v.rst = r; v.coin = c; v.cancel = can; v.vack = va; v.cack = ca;
    v.st = st; v.credit = 4'(cr); v.vreq = vr; v.creq = chr; v.rej = rj; v.busy = bz;
    vecs.push_back(v);
  endtask

  // Scoreboard compare
  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s step %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  initial begin
    //   rst coin         can va ca  state    cr vreq creq rej busy
    // Nickel, dime: exact price, no change.
    add(1, COIN_NONE,     0, 0, 0, IDLE,    0, 0, 0, 0, 0);
    add(0, COIN_NICKEL,   0, 0, 0, COLLECT, 1, 0, 0, 0, 0);
    add(0, COIN_DIME,     0, 0, 0, VEND,    3, 1, 0, 0, 1);
    add(0, COIN_NONE,     0, 0, 0, VEND,    3, 1, 0, 0, 1);
    add(0, COIN_NONE,     0, 1, 0, IDLE,    0, 0, 0, 0, 0);
    add(0, COIN_NONE,     0, 0, 0, IDLE,    0, 0, 0, 0, 0);
    // Dime, dime: one nickel change.
    add(0, COIN_DIME,     0, 0, 0, COLLECT, 2, 0, 0, 0, 0);
    add(0, COIN_DIME,     0, 0, 0, VEND,    4, 1, 0, 0, 1);
    add(0, COIN_NONE,     0, 1, 0, CHANGE,  1, 0, 1, 0, 1);
    add(0, COIN_NONE,     0, 0, 1, IDLE,    0, 0, 0, 0, 0);
    // Cancel together with a dime refunds all three nickels.
    add(0, COIN_NICKEL,   0, 0, 0, COLLECT, 1, 0, 0, 0, 0);
    add(0, COIN_DIME,     1, 0, 0, CHANGE,  3, 0, 1, 0, 1);
    add(0, COIN_NONE,     0, 0, 1, CHANGE,  2, 0, 1, 0, 1);
    add(0, COIN_NONE,     0, 0, 0, CHANGE,  2, 0, 1, 0, 1);
    add(0, COIN_NONE,     0, 0, 1, CHANGE,  1, 0, 1, 0, 1);
    add(0, COIN_NONE,     0, 0, 1, IDLE,    0, 0, 0, 0, 0);
    // Rejections: invalid code in IDLE, coins during VEND and CHANGE.
    add(0, COIN_INVALID,  0, 0, 0, IDLE,    0, 0, 0, 1, 0);
    add(0, COIN_NONE,     0, 0, 0, IDLE,    0, 0, 0, 0, 0);
    add(0, COIN_DIME,     0, 0, 0, COLLECT, 2, 0, 0, 0, 0);
    add(0, COIN_DIME,     0, 0, 0, VEND,    4, 1, 0, 0, 1);
    add(0, COIN_NICKEL,   0, 0, 0, VEND,    4, 1, 0, 1, 1);
    add(0, COIN_DIME,     0, 1, 0, CHANGE,  1, 0, 1, 1, 1);
    add(0, COIN_NICKEL,   0, 0, 1, IDLE,    0, 0, 0, 1, 0);
    add(0, COIN_NONE,     0, 0, 0, IDLE,    0, 0, 0, 0, 0);
    add(0, COIN_NONE,     0, 1, 1, IDLE,    0, 0, 0, 0, 0);
    // Timeout after four idle COLLECT cycles.
    add(0, COIN_NICKEL,   0, 0, 0, COLLECT, 1, 0, 0, 0, 0);
    add(0, COIN_NONE,     0, 0, 0, COLLECT, 1, 0, 0, 0, 0);
    add(0, COIN_NONE,     0, 0, 0, COLLECT, 1, 0, 0, 0, 0);
    add(0, COIN_NONE,     0, 0, 0, COLLECT, 1, 0, 0, 0, 0);
    add(0, COIN_NONE,     0, 0, 0, CHANGE,  1, 0, 1, 0, 1);
    add(0, COIN_NONE,     0, 0, 1, IDLE,    0, 0, 0, 0, 0);
    // A coin at idle count 2 restarts the timeout.
    add(0, COIN_NICKEL,   0, 0, 0, COLLECT, 1, 0, 0, 0, 0);
    add(0, COIN_NONE,     0, 0, 0, COLLECT, 1, 0, 0, 0, 0);
    add(0, COIN_NONE,     0, 0, 0, COLLECT, 1, 0, 0, 0, 0);
    add(0, COIN_NICKEL,   0, 0, 0, COLLECT, 2, 0, 0, 0, 0);
    add(0, COIN_NONE,     0, 0, 0, COLLECT, 2, 0, 0, 0, 0);
    add(0, COIN_NONE,     0, 0, 0, COLLECT, 2, 0, 0, 0, 0);
    add(0, COIN_NONE,     0, 0, 0, COLLECT, 2, 0, 0, 0, 0);
    add(0, COIN_NONE,     0, 0, 0, CHANGE,  2, 0, 1, 0, 1);
    // Reset during CHANGE drops credit; later change_ack ignored.
    add(1, COIN_NONE,     0, 0, 0, IDLE,    0, 0, 0, 0, 0);
    add(0, COIN_NONE,     0, 0, 1, IDLE,    0, 0, 0, 0, 0);
    // Cancel ignored in IDLE, honoured in COLLECT.
    add(0, COIN_NONE,     1, 0, 0, IDLE,    0, 0, 0, 0, 0);
    add(0, COIN_NICKEL,   1, 0, 0, COLLECT, 1, 0, 0, 0, 0);
    add(0, COIN_NONE,     1, 0, 0, CHANGE,  1, 0, 1, 0, 1);
    add(0, COIN_NONE,     0, 0, 1, IDLE,    0, 0, 0, 0, 0);
    // vend_ack already high on the first VEND cycle completes in one cycle.
    add(0, COIN_DIME,     0, 1, 0, COLLECT, 2, 0, 0, 0, 0);
    add(0, COIN_NICKEL,   0, 1, 0, VEND,    3, 1, 0, 0, 1);
    add(0, COIN_NONE,     0, 1, 0, IDLE,    0, 0, 0, 0, 0);

    // Driver loop
    for (int i = 0; i < vecs.size(); i++) begin
      rst        = vecs[i].rst;
      coin       = vecs[i].coin;
      cancel     = vecs[i].cancel;
      vend_ack   = vecs[i].vack;
      change_ack = vecs[i].cack;
      @(posedge clk);
      #1;
      check("state",       i, 32'(dbg_state),   32'(vecs[i].st));
      check("credit",      i, 32'(credit),      32'(vecs[i].credit));
      check("vend_req",    i, 32'(vend_req),    32'(vecs[i].vreq));
      check("change_req",  i, 32'(change_req),  32'(vecs[i].creq));
      check("coin_reject", i, 32'(coin_reject), 32'(vecs[i].rej));
      check("busy",        i, 32'(busy),        32'(vecs[i].busy));
    end
    rst = 1'b0; coin = COIN_NONE; cancel = 1'b0; vend_ack = 1'b0; change_ack = 1'b0;

    // Narrow credit: 2 + dime would wrap a 2-bit register, so it is rejected.
    rst2 = 1'b0; coin2 = COIN_DIME;
    @(posedge clk); #1;
    check("sat_credit", 100, 32'(credit2),      32'd2);
    check("sat_state",  100, 32'(dbg_state2),   32'(COLLECT));
    check("sat_rej",    100, 32'(coin_reject2), 32'd0);
    coin2 = COIN_DIME;
    @(posedge clk); #1;
    check("sat_credit", 101, 32'(credit2),      32'd2);
    check("sat_rej",    101, 32'(coin_reject2), 32'd1);
    check("sat_state",  101, 32'(dbg_state2),   32'(COLLECT));
    coin2 = COIN_NICKEL;
    @(posedge clk); #1;
    check("sat_credit", 102, 32'(credit2),      32'd3);
    check("sat_rej",    102, 32'(coin_reject2), 32'd0);
    check("sat_vreq",   102, 32'(vend_req2),    32'd1);
    coin2 = COIN_NONE; vend_ack2 = 1'b1;
    @(posedge clk); #1;
    check("sat_credit", 103, 32'(credit2),      32'd0);
    check("sat_state",  103, 32'(dbg_state2),   32'(IDLE));
    check("sat_busy",   103, 32'(busy2),        32'd0);
    check("sat_creq",   103, 32'(change_req2),  32'd0);
    vend_ack2 = 1'b0;

    // Final report
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
